// File: rtl/data_mem_waitstate_if.sv
// Request/response bus between the processor memory stage and data_mem_waitstate.
// The master drives requests; the slave answers with ready, response and stall.
interface data_mem_waitstate_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);
   logic              req_valid;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              req_ready;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              stall;

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, stall
   );
endinterface

// File: rtl/data_mem_waitstate.sv
// Data memory with configurable wait states, valid/ready request handshake,
// pipeline stall output, out-of-range detection and a saturating stall counter.
module data_mem_waitstate #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 16,
   parameter int DEPTH     = 256,
   parameter int LATENCY   = 2,
   parameter int BYTE_ADDR = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   data_mem_waitstate_if.slave   bus,
   input  logic                  clr_count,
   output logic [31:0]           stall_count
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              write_q, write_d;
   logic              oob_q, oob_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [31:0]       stall_count_q, stall_count_d;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [ADDR_W-1:0] req_word;
   logic [IDX_W-1:0]  req_idx;
   logic              req_oob;
   logic              req_ready;
   logic              accept;
   logic              stall;
   logic              rsp_valid;
   logic              rsp_err;
   logic              mem_we;
   logic [IDX_W-1:0]  rd_idx;
   logic              rd_oob;
   logic              rd_write;

   // Address decode of the incoming request.
   always_comb begin
      // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
      req_word = bus.req_addr;
      if (BYTE_ADDR != 0) begin
         req_word = bus.req_addr >> 1;
      end
      req_idx = req_word[IDX_W-1:0];
      req_oob = 32'(req_word) >= 32'(DEPTH);
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic; the wait counter exits WAIT once it reaches 1.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (LATENCY == 0) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_W'(LATENCY);
               end
            end
         end
         WAIT: begin
            if (cnt_q <= 3'd1) begin
               state_d = RESP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic. Ready is also held low while reset is asserted.
   always_comb begin
      req_ready = (state_q == IDLE) && reset;
      accept    = bus.req_valid && req_ready;
      stall     = ((state_q == IDLE) && bus.req_valid) || (state_q == WAIT);
      rsp_valid = (state_q == RESP);
      rsp_err   = (state_q == RESP) && oob_q;
      mem_we    = (state_q == RESP) && write_q && !oob_q;
   end

   // Request capture and the registered response data.
   always_comb begin
      write_d = write_q;
      oob_d   = oob_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      if (accept) begin
         write_d = bus.req_write;
         oob_d   = req_oob;
         idx_d   = req_idx;
         wdata_d = bus.req_wdata;
      end

      // With zero latency RESP is entered on the accept edge, before the latches hold the request.
      rd_idx   = idx_q;
      rd_oob   = oob_q;
      rd_write = write_q;
      if (state_q == IDLE) begin
         rd_idx   = req_idx;
         rd_oob   = req_oob;
         rd_write = bus.req_write;
      end

      rsp_rdata_d = rsp_rdata_q;
      if (state_d == RESP) begin
         rsp_rdata_d = (rd_write || rd_oob) ? '0 : mem[rd_idx];
      end
   end

   always_comb begin
      stall_count_d = stall_count_q;
      if (clr_count) begin
         stall_count_d = '0;
      end else if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
         stall_count_d = stall_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         write_q       <= 1'b0;
         oob_q         <= 1'b0;
         idx_q         <= '0;
         wdata_q       <= '0;
         rsp_rdata_q   <= '0;
         stall_count_q <= '0;
      end else begin
         write_q       <= write_d;
         oob_q         <= oob_d;
         idx_q         <= idx_d;
         wdata_q       <= wdata_d;
         rsp_rdata_q   <= rsp_rdata_d;
         stall_count_q <= stall_count_d;
      end
   end

   // NOTE: the array has no reset; its contents are undefined until written, which keeps it mappable to RAM.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[idx_q] <= wdata_q;
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err;
   assign bus.stall     = stall;
   assign stall_count   = stall_count_q;

endmodule

// File: tb/tb_data_mem_waitstate.sv
// Self-checking bench for data_mem_waitstate: directed steps plus randomized accesses,
// checked against a word-level memory model and a cycle-count model of stall time.
module tb_data_mem_waitstate;

   localparam int DW    = 16;
   localparam int AW    = 16;
   localparam int DEPTH = 256;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   data_mem_waitstate_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
   data_mem_waitstate_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

   logic        t_clr [2];
   logic [31:0] o_cnt [2];

   // Instance 0: word addressing, two wait cycles. Instance 1: byte addressing, no wait.
   data_mem_waitstate #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .LATENCY(2), .BYTE_ADDR(0)) dut0 (
      .clk(clk), .reset(reset), .bus(bus0), .clr_count(t_clr[0]), .stall_count(o_cnt[0])
   );
   data_mem_waitstate #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .LATENCY(0), .BYTE_ADDR(1)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1), .clr_count(t_clr[1]), .stall_count(o_cnt[1])
   );

   logic          t_valid [2];
   logic          t_write [2];
   logic [AW-1:0] t_addr  [2];
   logic [DW-1:0] t_wdata [2];
   logic          o_ready [2];
   logic          o_rvld  [2];
   logic [DW-1:0] o_rdata [2];
   logic          o_err   [2];
   logic          o_stall [2];

   assign bus0.req_valid = t_valid[0];
   assign bus0.req_write = t_write[0];
   assign bus0.req_addr  = t_addr[0];
   assign bus0.req_wdata = t_wdata[0];
   assign bus1.req_valid = t_valid[1];
   assign bus1.req_write = t_write[1];
   assign bus1.req_addr  = t_addr[1];
   assign bus1.req_wdata = t_wdata[1];
   assign o_ready[0] = bus0.req_ready;
   assign o_rvld[0]  = bus0.rsp_valid;
   assign o_rdata[0] = bus0.rsp_rdata;
   assign o_err[0]   = bus0.rsp_err;
   assign o_stall[0] = bus0.stall;
   assign o_ready[1] = bus1.req_ready;
   assign o_rvld[1]  = bus1.rsp_valid;
   assign o_rdata[1] = bus1.rsp_rdata;
   assign o_err[1]   = bus1.rsp_err;
   assign o_stall[1] = bus1.stall;

   int checks = 0;
   int errors = 0;

   // Reference model: word contents per instance and expected stall-cycle total.
   logic [DW-1:0] model_mem   [2][DEPTH];
   bit            model_known [2][DEPTH];
   longint        exp_cnt     [2];

   function automatic int lat_of(input int s);
      return (s == 0) ? 2 : 0;
   endfunction

   function automatic longint sat32(input longint v);
      return (v > 64'h0000_0000_FFFF_FFFF) ? 64'h0000_0000_FFFF_FFFF : v;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete access on instance s, checked cycle by cycle against the model.
   task automatic access(input int s, input bit wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input bit clr, input bit preload);
      int      word;
      bit      oob;
      int      n;
      bit      got;
      bit      rd_known;
      logic [DW-1:0] exp_rd;
      word = (s == 1) ? int'(addr >> 1) : int'(addr);
      oob  = (word >= DEPTH);
      @(negedge clk);
      t_valid[s] = 1'b1;
      t_write[s] = wr;
      t_addr[s]  = addr;
      t_wdata[s] = wd;
      t_clr[s]   = clr;
      if (preload) force dut0.stall_count_q = 32'hFFFF_FFFD;
      #1;
      check("req_ready_idle", 32'(o_ready[s]), 32'd1);
      check("stall_idle_req", 32'(o_stall[s]), 32'd1);
      @(posedge clk);
      #1;
      if (preload) release dut0.stall_count_q;
      // Scramble the request lines; the block must use its latched copy.
      t_valid[s] = 1'b0;
      t_clr[s]   = 1'b0;
      t_write[s] = 1'($urandom);
      t_addr[s]  = AW'($urandom);
      t_wdata[s] = DW'($urandom);
      if (clr) begin
         exp_cnt[s] = 0;
         check("stall_count_clr", o_cnt[s], 32'd0);
      end else if (preload) begin
         exp_cnt[s] = 64'h0000_0000_FFFF_FFFE;
      end else begin
         exp_cnt[s] = sat32(exp_cnt[s] + 1);
      end
      exp_cnt[s] = sat32(exp_cnt[s] + longint'(lat_of(s)));

      n   = 0;
      got = 1'b0;
      while (!got && n < 20) begin
         @(negedge clk);
         n++;
         if (o_rvld[s]) got = 1'b1;
         else check("stall_wait", 32'(o_stall[s]), 32'd1);
      end
      check("rsp_seen", 32'(got), 32'd1);
      check("latency", 32'(n), 32'(lat_of(s) + 1));
      check("stall_resp", 32'(o_stall[s]), 32'd0);
      check("rsp_err", 32'(o_err[s]), 32'(oob));

      rd_known = 1'b1;
      exp_rd   = '0;
      if (!wr && !oob) begin
         rd_known = model_known[s][word];
         exp_rd   = model_mem[s][word];
      end
      if (rd_known) check("rsp_rdata", 32'(o_rdata[s]), 32'(exp_rd));
      if (wr && !oob) begin
         model_mem[s][word]   = wd;
         model_known[s][word] = 1'b1;
      end

      @(negedge clk);
      check("rsp_valid_pulse", 32'(o_rvld[s]), 32'd0);
      if (rd_known) check("rdata_hold", 32'(o_rdata[s]), 32'(exp_rd));
      check("stall_count", o_cnt[s], exp_cnt[s][31:0]);
   endtask

   initial begin
      for (int s = 0; s < 2; s++) begin
         t_valid[s] = 1'b0;
         t_write[s] = 1'b0;
         t_addr[s]  = '0;
         t_wdata[s] = '0;
         t_clr[s]   = 1'b0;
         exp_cnt[s] = 0;
         for (int w = 0; w < DEPTH; w++) model_known[s][w] = 1'b0;
      end

      // Reset held with a request pending.
      reset      = 1'b0;
      t_valid[0] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("rst_req_ready", 32'(o_ready[0]), 32'd0);
      check("rst_stall", 32'(o_stall[0]), 32'd1);
      check("rst_rsp_valid", 32'(o_rvld[0]), 32'd0);
      check("rst_rsp_rdata", 32'(o_rdata[0]), 32'd0);
      check("rst_rsp_err", 32'(o_err[0]), 32'd0);
      check("rst_stall_count", o_cnt[0], 32'd0);
      t_valid[0] = 1'b0;
      reset      = 1'b1;
      #1;
      check("post_rst_ready", 32'(o_ready[0]), 32'd1);
      check("post_rst_stall", 32'(o_stall[0]), 32'd0);

      // Store then load with two wait cycles.
      access(0, 1'b1, 16'd5, 16'h1234, 1'b0, 1'b0);
      access(0, 1'b0, 16'd5, 16'h0000, 1'b0, 1'b0);
      check("stall_count_six", o_cnt[0], 32'd6);

      // Zero latency, byte addressing: both bytes of word 5.
      access(1, 1'b1, 16'h000A, 16'hBEEF, 1'b0, 1'b0);
      access(1, 1'b0, 16'h000B, 16'h0000, 1'b0, 1'b0);

      // Out of range: word 300 aliases index 44 if the range check is missing.
      access(0, 1'b1, 16'd44, 16'h4444, 1'b0, 1'b0);
      access(0, 1'b1, 16'd300, 16'hDEAD, 1'b0, 1'b0);
      access(0, 1'b0, 16'd300, 16'h0000, 1'b0, 1'b0);
      access(0, 1'b0, 16'd44, 16'h0000, 1'b0, 1'b0);
      access(1, 1'b1, 16'hFFFF, 16'h7777, 1'b0, 1'b0);

      // Reset during WAIT discards the pending store.
      access(0, 1'b1, 16'd9, 16'h0001, 1'b0, 1'b0);
      @(negedge clk);
      t_valid[0] = 1'b1;
      t_write[0] = 1'b1;
      t_addr[0]  = 16'd9;
      t_wdata[0] = 16'h5555;
      @(posedge clk);
      #1;
      t_valid[0] = 1'b0;
      @(negedge clk);
      check("wait_before_rst", 32'(o_stall[0]), 32'd1);
      reset = 1'b0;
      #1;
      check("mid_rst_rsp_valid", 32'(o_rvld[0]), 32'd0);
      @(negedge clk);
      check("mid_rst_rsp_valid2", 32'(o_rvld[0]), 32'd0);
      reset      = 1'b1;
      exp_cnt[0] = 0;
      exp_cnt[1] = 0;
      @(negedge clk);
      check("after_rst_rsp_valid", 32'(o_rvld[0]), 32'd0);
      access(0, 1'b0, 16'd9, 16'h0000, 1'b0, 1'b0);

      // Randomized accesses on both instances, mostly in range with some out of range.
      for (int i = 0; i < 80; i++) begin
         int       s;
         int       w;
         logic [AW-1:0] a;
         s = int'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) w = int'($urandom_range(DEPTH, 16'h7FFF));
         else w = int'($urandom_range(0, 23));
         a = (s == 1) ? AW'(w * 2 + int'($urandom_range(0, 1))) : AW'(w);
         access(s, 1'($urandom), a, DW'($urandom), ($urandom_range(0, 9) == 0), 1'b0);
      end

      // Saturation near the top of the counter, then clear together with a stall.
      access(0, 1'b0, 16'd5, 16'h0000, 1'b0, 1'b1);
      check("stall_count_sat", o_cnt[0], 32'hFFFF_FFFF);
      access(0, 1'b1, 16'd6, 16'hA5A5, 1'b0, 1'b0);
      check("stall_count_sat_hold", o_cnt[0], 32'hFFFF_FFFF);
      access(0, 1'b0, 16'd6, 16'h0000, 1'b1, 1'b0);
      check("stall_count_after_clr", o_cnt[0], 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_mem_waitstate.md
Name: data_mem_waitstate

Overview:
- Parametrised successor to the single-cycle data memory used by the pipelined processor.
- Adds configurable access latency, a valid/ready request handshake, a pipeline stall output, out-of-range detection and a stall-cycle performance counter.
- Sits between the processor memory stage and backing storage; the hazard unit ORs `stall` into its Fetch/Decode stall and Execute flush logic.

Parameters:
- DATA_W, 16, data word width in bits.
- ADDR_W, 16, request address width in bits.
- DEPTH, 256, number of words in the array; valid word indices are 0..DEPTH-1.
- LATENCY, 2, wait cycles between request accept and response; legal range 0..7.
- BYTE_ADDR, 0: 0 means req_addr is a word index; 1 means req_addr is a byte address, with word index = req_addr >> 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  memory-stage request present.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_W  access address.
- req_wdata  input  DATA_W  store data.
- req_ready  output  1  block can accept a request this cycle.
- rsp_valid  output  1  one-cycle pulse: access complete.
- rsp_rdata  output  DATA_W  load data; valid when rsp_valid=1.
- rsp_err  output  1  pulses with rsp_valid when the address was out of range.
- stall  output  1  processor must hold its memory stage.
- clr_count  input  1  synchronous clear of stall_count.
- stall_count  output  32  saturating count of cycles with stall=1.

Behaviour:
- Reset (reset=0), asynchronous:
  - state=IDLE, wait counter=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, stall_count=0.
  - Array contents are not reset.
- States: IDLE, WAIT, RESP.
- req_ready=1 only in IDLE. A request is accepted when req_valid=1 and req_ready=1; write, word index and wdata are latched on that edge.
- IDLE -> WAIT on accept, counter loaded with LATENCY. If LATENCY=0, IDLE -> RESP directly.
- WAIT: counter decrements each cycle. When the counter reaches 1 (i.e. after LATENCY WAIT cycles), go to RESP.
- RESP lasts one cycle, then returns to IDLE:
  - rsp_valid=1.
  - A write commits to the array on the edge leaving RESP.
  - Load data is read combinationally from the latched index and registered into rsp_rdata, so rsp_rdata is valid during RESP.
- Latency: accept at edge T gives rsp_valid high in the cycle after edge T+LATENCY.
- stall = (state==IDLE && req_valid) || state==WAIT. It is 0 in RESP, so the pipeline advances during the response cycle.
- Requests arriving in RESP are not accepted; they are accepted in the following IDLE cycle. Back-to-back throughput is one access per LATENCY+2 cycles.
- Out of range (word index >= DEPTH):
  - Write is dropped and the array is unchanged.
  - Read returns 0.
  - rsp_err=1 in RESP. Timing is identical to an in-range access.
- rsp_rdata holds its last value outside RESP. A write response sets rsp_rdata to 0.
- req_* may change while state != IDLE; they are ignored because the latched copies are used.
- Reset asserted mid-access returns to IDLE; a pending write is discarded and no rsp_valid pulse is produced.
- stall_count increments on every cycle with stall=1 and saturates at 0xFFFFFFFF.
  - clr_count=1 forces 0 on the next edge and has priority over increment.
- A read of a word written in the immediately preceding access returns the new value.

Test Plan:
- Reset: hold reset=0 with req_valid=1 -> req_ready=0, stall=1 (combinational), rsp_valid=0, stall_count=0. Release -> IDLE, req_ready=1.
- LATENCY=2 store then load:
  - Store 0x1234 to addr 5 accepted at cycle 0 -> stall=1 in cycles 0–2, rsp_valid in cycle 3.
  - Load of addr 5 accepted at cycle 4 -> rsp_rdata=0x1234 with rsp_valid in cycle 7.
  - stall_count=6.
- LATENCY=0, BYTE_ADDR=1: store 0xBEEF to byte addr 0x000A -> word 5 written, rsp_valid in the cycle after accept. Load of byte addr 0x000B also returns 0xBEEF.
- Out of range, DEPTH=256: store to word 300 -> rsp_err=1 with rsp_valid, array unchanged. Load of word 300 -> rsp_rdata=0, rsp_err=1.
- Reset during WAIT of a store of 0x5555 to addr 9 (previous value 0x0001) -> no rsp_valid, addr 9 still 0x0001, next request accepted normally.
- Counter: preload stall_count near 0xFFFFFFFF via a forced value and keep stall=1 -> stays 0xFFFFFFFF. Pulse clr_count together with stall=1 -> 0 on the next edge.
